// File: rtl/golden_nonce_collector_pkg.sv
// Shared widths and helpers for the golden nonce collector.
// No logic; imported by the interface, the FIFO and the top.
package golden_nonce_pkg;

    localparam int NONCE_W    = 32;
    localparam int DROP_CNT_W = 16;

    // Width of a core index: at least one bit even for a single core.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/golden_nonce_collector_if.sv
// Core-array inputs and host-side valid/ready stream of the collector.
// slave = collector side, master = core array / host side.
interface golden_nonce_collector_if
    import golden_nonce_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CORE_ID_W = 2
);

    logic [NUM_CORES-1:0]         core_nonce_valid;
    logic [NONCE_W*NUM_CORES-1:0] core_nonce;
    logic                         out_valid;
    logic                         out_ready;
    logic [NONCE_W-1:0]           out_nonce;
    logic [CORE_ID_W-1:0]         out_core_id;

    modport master (
        output core_nonce_valid, core_nonce, out_ready,
        input  out_valid, out_nonce, out_core_id
    );

    modport slave (
        input  core_nonce_valid, core_nonce, out_ready,
        output out_valid, out_nonce, out_core_id
    );

endinterface

// File: rtl/golden_nonce_collector_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into an empty FIFO is visible next cycle.
// Push while full is accepted only together with a pop; the head holds its last value while empty.
module nonce_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                       hash_clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic             wr_en;
    logic             rd_en;

    assign rd_en  = pop && (count != '0);
    assign wr_en  = push && ((count != CW'(DEPTH)) || rd_en);
    assign rd_nxt = rd_ptr + AW'(1);

    always_ff @(posedge hash_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_nxt;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Registered head: the pushed word bypasses memory when it becomes the new head.
            if (wr_en && ((count == '0) || ((count == CW'(1)) && rd_en))) begin
                dout <= din;
            end else if (rd_en && (count > CW'(1))) begin
                dout <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/golden_nonce_collector.sv
// Per-core one-entry slots drained round-robin into a FWFT FIFO; pulse to out_valid is 2 cycles.
// A full FIFO stalls slots losslessly; a new pulse onto a still-pending slot is dropped and counted.
module golden_nonce_collector
    import golden_nonce_pkg::*;
#(
    parameter int                 NUM_CORES    = 4,
    parameter int                 FIFO_DEPTH   = 8,
    parameter logic [NONCE_W-1:0] NONCE_ADJUST = '0,
    parameter int                 CORE_ID_W    = id_width(NUM_CORES)
) (
    input  logic                        hash_clk,
    input  logic                        reset_n,
    golden_nonce_collector_if.slave     bus,
    input  logic                        clear_stats,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [DROP_CNT_W-1:0]       drop_count,
    output logic                        overflow
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int FW   = NONCE_W + CORE_ID_W;
    localparam int DN_W = $clog2(NUM_CORES + 1);
    localparam int SW   = DROP_CNT_W + 1;

    logic [NUM_CORES-1:0] slot_pend;
    logic [NONCE_W-1:0]   slot_dat [NUM_CORES];
    logic [CORE_ID_W-1:0] rr_ptr;
    logic [CORE_ID_W-1:0] gnt_idx;
    logic                 gnt_any;
    logic                 grant;
    logic                 pop;
    logic                 can_push;
    logic [NUM_CORES-1:0] drop;
    logic [DN_W-1:0]      drop_num;
    logic [SW-1:0]        drop_sum;
    logic [FW-1:0]        fifo_dout;

    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign can_push      = (fifo_count != CW'(FIFO_DEPTH)) || pop;
    assign grant         = gnt_any && can_push;

    // First pending slot at or after the round-robin pointer.
    always_comb begin
        int                   idx;
        logic [CORE_ID_W-1:0] sel;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CORES;
            sel = CORE_ID_W'(idx);
            if (!gnt_any && slot_pend[sel]) begin
                gnt_any = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    always_comb begin
        drop     = '0;
        drop_num = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            drop[i]  = bus.core_nonce_valid[i] && slot_pend[i] &&
                       !(grant && (gnt_idx == CORE_ID_W'(i)));
            drop_num = drop_num + DN_W'(drop[i]);
        end
        // A clear starts the count from zero but still records this cycle's drops.
        drop_sum = (clear_stats ? '0 : {1'b0, drop_count}) + SW'(drop_num);
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_pend  <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_dat[i] <= '0;
            end
        end else begin
            if (grant) begin
                rr_ptr <= (gnt_idx == CORE_ID_W'(NUM_CORES - 1)) ? '0 : gnt_idx + CORE_ID_W'(1);
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus.core_nonce_valid[i] && !drop[i]) begin
                    slot_dat[i]  <= bus.core_nonce[NONCE_W*i +: NONCE_W] + NONCE_ADJUST;
                    slot_pend[i] <= 1'b1;
                end else if (grant && (gnt_idx == CORE_ID_W'(i))) begin
                    slot_pend[i] <= 1'b0;
                end
            end
            drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
            overflow   <= (|drop) ? 1'b1 : (clear_stats ? 1'b0 : overflow);
        end
    end

    nonce_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .push     (grant),
        .din      ({gnt_idx, slot_dat[gnt_idx]}),
        .pop      (pop),
        .dout     (fifo_dout),
        .count    (fifo_count)
    );

    assign bus.out_nonce   = fifo_dout[NONCE_W-1:0];
    assign bus.out_core_id = fifo_dout[FW-1:NONCE_W];

endmodule
